// File: rtl/seq_symbol_feeder.sv
// Serializes packed sequence words into 2-bit nucleotide symbols for the
// sequence-matching core, one symbol every SYM_PERIOD cycles, MSB-first.
module seq_symbol_feeder #(
  parameter int WORD_W     = 32,
  parameter int SYM_PERIOD = 2,
  parameter int LEN_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [1:0]        symbol,
  output logic              sym_valid,
  output logic              BC_mode,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  localparam int SYMS = WORD_W / 2;
  localparam int SC_W = $clog2(SYMS + 1);
  localparam int WC_W = LEN_W + 1 - $clog2(SYMS);
  localparam int PC_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, STALL} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sh_q, pf_q;
  logic [SC_W-1:0]   sh_cnt;     // symbols in sh_q, current symbol included
  logic              pf_vld;
  logic [LEN_W-1:0]  sym_left;
  logic [WC_W-1:0]   words_left, words_init;
  logic [PC_W-1:0]   per_cnt;
  logic [LEN_W:0]    len_round;
  logic              accept, boundary, last, can_shift, no_data, load_sh, load_pf, starve;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start && seq_len != '0) state_d = LOAD;
      LOAD, STALL: if (accept) state_d = STREAM;
      STREAM: begin
        if (last)        state_d = IDLE;
        else if (starve) state_d = STALL;
      end
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = busy && (words_left != '0) && (sh_cnt == '0 || !pf_vld);
    accept     = in_valid && in_ready;
    boundary   = (state_q == STREAM) && (per_cnt == PC_W'(SYM_PERIOD - 1));
    last       = boundary && (sym_left == LEN_W'(1));
    can_shift  = sh_cnt > SC_W'(1);
    no_data    = boundary && !last && !can_shift && !pf_vld;
    // A word arriving exactly on a starved boundary goes straight to the shifter.
    load_sh    = accept && (sh_cnt == '0 || no_data);
    load_pf    = accept && !load_sh;
    starve     = no_data && !accept;
    len_round  = {1'b0, seq_len} + (LEN_W+1)'(SYMS - 1);
    words_init = WC_W'(len_round / (LEN_W+1)'(SYMS));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_q       <= '0;
      pf_q       <= '0;
      sh_cnt     <= '0;
      pf_vld     <= 1'b0;
      sym_left   <= '0;
      words_left <= '0;
      per_cnt    <= '0;
      symbol     <= 2'b00;
      sym_valid  <= 1'b0;
      BC_mode    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      sym_valid <= 1'b0;
      if (state_q == STREAM) per_cnt <= boundary ? '0 : per_cnt + PC_W'(1);
      if (accept) words_left <= words_left - WC_W'(1);
      if (state_q == IDLE && start) begin
        if (seq_len == '0) done <= 1'b1;
        else begin
          busy       <= 1'b1;
          underrun   <= 1'b0;
          sym_left   <= seq_len;
          words_left <= words_init;
        end
      end
      if (boundary) begin
        sym_left <= sym_left - LEN_W'(1);
        if (last) begin
          BC_mode <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          sh_cnt  <= '0;
          pf_vld  <= 1'b0;
        end else if (can_shift) begin
          sh_q      <= {sh_q[WORD_W-3:0], 2'b00};
          sh_cnt    <= sh_cnt - SC_W'(1);
          symbol    <= sh_q[WORD_W-3 -: 2];
          sym_valid <= 1'b1;
        end else if (pf_vld) begin
          sh_q      <= pf_q;
          sh_cnt    <= SC_W'(SYMS);
          pf_vld    <= 1'b0;
          symbol    <= pf_q[WORD_W-1 -: 2];
          sym_valid <= 1'b1;
        end else begin
          sh_cnt <= '0;
          if (!accept) underrun <= 1'b1;
        end
      end
      if (load_sh) begin
        sh_q      <= in_data;
        sh_cnt    <= SC_W'(SYMS);
        symbol    <= in_data[WORD_W-1 -: 2];
        sym_valid <= 1'b1;
        BC_mode   <= 1'b1;
        per_cnt   <= '0;
      end
      if (load_pf) begin
        pf_q   <= in_data;
        pf_vld <= 1'b1;
      end
    end
  end
endmodule
